// File: rtl/adc_link_lock_seq_if.sv
// ADC link-lock bundle: deserialiser data in, bitslip out, lock/status out.
// Latency: none, wires only.
// Backpressure: none; the deserialiser must act on every bitslip pulse.
//
// Ports (master = lock sequencer, slave = deserialiser/capture side):
//   relock          restart request, one cycle
//   adc_data        deserialised ADC word
//   bitslip         one-cycle slip pulse to the deserialiser
//   gclk_sd_lockeda link locked / data-valid qualifier
//   align_fail      sticky alignment failure
//   slip_cnt        slips issued in the current attempt
//   retry_cnt       restarts since reset or relock (saturating)
//   lock_state      sequencer state code
interface adc_link_lock_seq_if #(
  parameter int DATA_W = 8,
  parameter int SLIP_W = 4
);
  logic              relock;
  logic [DATA_W-1:0] adc_data;
  logic              bitslip;
  logic              gclk_sd_lockeda;
  logic              align_fail;
  logic [SLIP_W-1:0] slip_cnt;
  logic [3:0]        retry_cnt;
  logic [2:0]        lock_state;

  modport master (
    input  relock, adc_data,
    output bitslip, gclk_sd_lockeda, align_fail, slip_cnt, retry_cnt, lock_state
  );

  modport slave (
    output relock, adc_data,
    input  bitslip, gclk_sd_lockeda, align_fail, slip_cnt, retry_cnt, lock_state
  );
endinterface

// File: rtl/adc_link_lock_seq.sv
// ADC link lock sequencer: settle, bit-align the training word via bitslip, then assert lock.
// Latency: lock SETTLE_CYCLES+MATCH_CNT+1 edges after reset release when already aligned.
// Backpressure: none; each bitslip is followed by SLIP_WAIT idle cycles before re-checking.
//
// Ports: clk_div_a (only clock), sys_rst_n (async active-low reset),
//   bufg_rst (async restart request, synchronised here), lnk (master modport:
//   relock/adc_data in; bitslip, gclk_sd_lockeda, align_fail, slip_cnt,
//   retry_cnt, lock_state out).
// Optional: define ADC_LOCK_TIMEOUT_EN to enter a sticky FAIL state after
//   MAX_RETRY restarts; otherwise retries continue forever and align_fail is 0.
module adc_link_lock_seq #(
  parameter int              DATA_W        = 8,
  parameter int              SLIP_W        = 4,
  parameter int              SETTLE_CYCLES = 256,
  parameter int              MATCH_CNT     = 16,
  parameter int              SLIP_WAIT     = 4,
  parameter logic [DATA_W-1:0] TRAIN_PAT   = 8'hF0,
  parameter int              MAX_RETRY     = 3
) (
  input  logic                 clk_div_a,
  input  logic                 sys_rst_n,
  input  logic                 bufg_rst,
  adc_link_lock_seq_if.master  lnk
);

  localparam int CYC_W   = $clog2(SETTLE_CYCLES + SLIP_WAIT);
  localparam int MATCH_W = $clog2(MATCH_CNT + 1);

  if (SLIP_W < $clog2(DATA_W + 1)) begin : g_slip_w_chk
    $error("SLIP_W too narrow to hold DATA_W");
  end
  if (MAX_RETRY > 15) begin : g_retry_chk
    $error("MAX_RETRY exceeds retry_cnt range");
  end

  typedef enum logic [2:0] {
    ST_SETTLE = 3'd0,
    ST_CHECK  = 3'd1,
    ST_SLIP   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_LOCKED = 3'd4,
    ST_FAIL   = 3'd5
  } state_t;

  state_t             state, state_nxt;
  logic [CYC_W-1:0]   cyc_cnt, cyc_nxt;
  logic [MATCH_W-1:0] match_cnt, match_nxt;
  logic [SLIP_W-1:0]  slip_cnt, slip_nxt;
  logic [3:0]         retry_cnt, retry_nxt, retry_sat;
  logic [2:0]         bufg_sync;
  logic               rst_sync, restart;
  logic [DATA_W-1:0]  adc_data_r;
  logic               data_primed;

  // bufg_rst is asynchronous to clk_div_a; three flops before use.
  always_ff @(posedge clk_div_a or negedge sys_rst_n) begin
    if (!sys_rst_n) bufg_sync <= '0;
    else            bufg_sync <= {bufg_sync[1:0], bufg_rst};
  end
  assign rst_sync = bufg_sync[2];
  assign restart  = rst_sync | lnk.relock;

  // data_primed holds SETTLE for the one cycle after reset in which
  // adc_data_r still carries its reset value rather than a real sample.
  always_ff @(posedge clk_div_a or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      adc_data_r  <= '0;
      data_primed <= 1'b0;
    end else begin
      adc_data_r  <= lnk.adc_data;
      data_primed <= 1'b1;
    end
  end

  always_ff @(posedge clk_div_a or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= ST_SETTLE;
      cyc_cnt   <= '0;
      match_cnt <= '0;
      slip_cnt  <= '0;
      retry_cnt <= '0;
    end else begin
      state     <= state_nxt;
      cyc_cnt   <= cyc_nxt;
      match_cnt <= match_nxt;
      slip_cnt  <= slip_nxt;
      retry_cnt <= retry_nxt;
    end
  end

  assign retry_sat = (retry_cnt == 4'hF) ? retry_cnt : retry_cnt + 4'd1;

  always_comb begin
    state_nxt = state;
    cyc_nxt   = cyc_cnt;
    match_nxt = match_cnt;
    slip_nxt  = slip_cnt;
    retry_nxt = retry_cnt;
    if (restart) begin
      state_nxt = ST_SETTLE;
      cyc_nxt   = '0;
      match_nxt = '0;
      slip_nxt  = '0;
      retry_nxt = '0;
    end else begin
      case (state)
        ST_SETTLE: begin
          if (data_primed) begin
            if (cyc_cnt == CYC_W'(SETTLE_CYCLES - 1)) begin
              state_nxt = ST_CHECK;
              cyc_nxt   = '0;
            end else begin
              cyc_nxt = cyc_cnt + CYC_W'(1);
            end
          end
        end
        ST_CHECK: begin
          if (adc_data_r == TRAIN_PAT) begin
            match_nxt = match_cnt + MATCH_W'(1);
            if (match_cnt == MATCH_W'(MATCH_CNT - 1)) state_nxt = ST_LOCKED;
          end else if (slip_cnt < SLIP_W'(DATA_W)) begin
            match_nxt = '0;
            state_nxt = ST_SLIP;
          end else begin
            // Every rotation tried without a match: restart the attempt.
            match_nxt = '0;
            slip_nxt  = '0;
            cyc_nxt   = '0;
`ifdef ADC_LOCK_TIMEOUT_EN
            if (retry_cnt == 4'(MAX_RETRY)) begin
              state_nxt = ST_FAIL;
            end else begin
              state_nxt = ST_SETTLE;
              retry_nxt = retry_sat;
            end
`else
            state_nxt = ST_SETTLE;
            retry_nxt = retry_sat;
`endif
          end
        end
        ST_SLIP: begin
          slip_nxt  = slip_cnt + SLIP_W'(1);
          cyc_nxt   = '0;
          state_nxt = ST_WAIT;
        end
        ST_WAIT: begin
          if (cyc_cnt == CYC_W'(SLIP_WAIT - 1)) begin
            cyc_nxt   = '0;
            state_nxt = ST_CHECK;
          end else begin
            cyc_nxt = cyc_cnt + CYC_W'(1);
          end
        end
        ST_LOCKED: state_nxt = ST_LOCKED;
`ifdef ADC_LOCK_TIMEOUT_EN
        ST_FAIL:   state_nxt = ST_FAIL;
`endif
        default:   state_nxt = ST_SETTLE;
      endcase
    end
  end

  assign lnk.bitslip         = (state == ST_SLIP);
  assign lnk.gclk_sd_lockeda = (state == ST_LOCKED);
`ifdef ADC_LOCK_TIMEOUT_EN
  assign lnk.align_fail      = (state == ST_FAIL);
`else
  assign lnk.align_fail      = 1'b0;
`endif
  assign lnk.slip_cnt        = slip_cnt;
  assign lnk.retry_cnt       = retry_cnt;
  assign lnk.lock_state      = state;

endmodule

// File: tb/tb_adc_link_lock_seq.sv
// Bench for adc_link_lock_seq: a rotating deserialiser model plus arithmetic
// expectations for lock edge, slip count, retry timing and burst sizes.
module tb_adc_link_lock_seq;
  localparam logic [7:0] PAT    = 8'hF0;
  localparam int SETTLE         = 256;
  localparam int MATCHES        = 16;
  localparam int SLIP_COST      = 6;
  localparam int ALIGNED_LOCK   = SETTLE + MATCHES + 1;
  // First exhausted-rotation edge after release, and the period between them.
  localparam int EXH_FIRST      = SETTLE + 1 + 1 + 8 * SLIP_COST;
  localparam int EXH_PERIOD     = SETTLE + 1 + 8 * SLIP_COST;
`ifdef ADC_LOCK_TIMEOUT_EN
  localparam int RETRY_CAP  = 3;
  localparam int FAIL_AFTER = 4;
  localparam int EXH_END    = EXH_FIRST + EXH_PERIOD * 3;
`else
  localparam int RETRY_CAP  = 15;
  localparam int FAIL_AFTER = 1000;
  localparam int EXH_END    = EXH_FIRST + EXH_PERIOD * 16;
`endif

  logic clk_div_a = 1'b0;
  logic sys_rst_n = 1'b1;
  logic bufg_rst  = 1'b0;

  adc_link_lock_seq_if #(.DATA_W(8), .SLIP_W(4)) lnk();

  adc_link_lock_seq dut (
    .clk_div_a (clk_div_a),
    .sys_rst_n (sys_rst_n),
    .bufg_rst  (bufg_rst),
    .lnk       (lnk)
  );

  always #5 clk_div_a = ~clk_div_a;

  int vectors = 0;
  int miscompares = 0;
  int edge_n = 0;
  int pulses = 0;
  logic slip_d = 1'b0;
  logic prev_bs = 1'b0;
  logic [7:0] word = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rotl(input logic [7:0] x);
    return {x[6:0], x[7]};
  endfunction

  function automatic logic [7:0] rotr_n(input logic [7:0] x, input int n);
    logic [7:0] y = x;
    for (int i = 0; i < n; i++) y = {y[0], y[7:1]};
    return y;
  endfunction

  function automatic bit in_pat_class(input logic [7:0] x);
    logic [7:0] y = x;
    for (int i = 0; i < 8; i++) begin
      if (y == PAT) return 1'b1;
      y = rotl(y);
    end
    return 1'b0;
  endfunction

  // One clock: observe just after the falling edge, then drive inputs.
  // A slip seen in one cycle rotates the word presented in the next.
  task automatic tick();
    @(negedge clk_div_a);
    edge_n++;
    if (lnk.bitslip) pulses++;
    check("bitslip_gap", 32'(lnk.bitslip & prev_bs), 32'd0);
    prev_bs = lnk.bitslip;
    if (slip_d) word = rotl(word);
    slip_d = lnk.bitslip;
    lnk.adc_data = word;
  endtask

  task automatic run_to(input int e);
    while (edge_n < e) tick();
  endtask

  task automatic do_reset(input logic [7:0] w);
    @(negedge clk_div_a);
    sys_rst_n = 1'b0;
    bufg_rst = 1'b0;
    lnk.relock = 1'b0;
    word = w;
    lnk.adc_data = w;
    slip_d = 1'b0;
    prev_bs = 1'b0;
    repeat (3) @(negedge clk_div_a);
    sys_rst_n = 1'b1;
    edge_n = 0;
    pulses = 0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_bitslip"}, 32'(lnk.bitslip), 32'd0);
    check({tag, "_locked"},  32'(lnk.gclk_sd_lockeda), 32'd0);
    check({tag, "_fail"},    32'(lnk.align_fail), 32'd0);
    check({tag, "_slip"},    32'(lnk.slip_cnt), 32'd0);
    check({tag, "_retry"},   32'(lnk.retry_cnt), 32'd0);
    check({tag, "_state"},   32'(lnk.lock_state), 32'd0);
  endtask

  initial begin
    int r, n, base, exp_retry;
    logic [7:0] bad;
    lnk.relock = 1'b0;
    lnk.adc_data = 8'h00;

    // Reset state.
    #1 sys_rst_n = 1'b0;
    #2 check_zero_outputs("reset");

    // Aligned from release: lock on edge 273, no slips.
    do_reset(PAT);
    run_to(ALIGNED_LOCK - 1);
    check("aligned_prelock", 32'(lnk.gclk_sd_lockeda), 32'd0);
    tick();
    check("aligned_lock", 32'(lnk.gclk_sd_lockeda), 32'd1);
    check("aligned_state", 32'(lnk.lock_state), 32'd4);
    check("aligned_pulses", 32'(pulses), 32'd0);
    check("aligned_slip", 32'(lnk.slip_cnt), 32'd0);

    // One-cycle relock drops lock at once and re-locks 272 cycles later.
    lnk.relock = 1'b1;
    tick();
    lnk.relock = 1'b0;
    base = edge_n;
    check("relock_drop", 32'(lnk.gclk_sd_lockeda), 32'd0);
    check("relock_state", 32'(lnk.lock_state), 32'd0);
    run_to(base + SETTLE + MATCHES - 1);
    check("relock_prelock", 32'(lnk.gclk_sd_lockeda), 32'd0);
    tick();
    check("relock_lock", 32'(lnk.gclk_sd_lockeda), 32'd1);

    // Random misalignment: r slips, each costing SLIP_COST cycles.
    for (int t = 0; t < 3; t++) begin
      r = int'($urandom_range(1, 7));
      do_reset(rotr_n(PAT, r));
      run_to(ALIGNED_LOCK + SLIP_COST * r - 1);
      check("rot_prelock", 32'(lnk.gclk_sd_lockeda), 32'd0);
      tick();
      check("rot_lock", 32'(lnk.gclk_sd_lockeda), 32'd1);
      check("rot_pulses", 32'(pulses), 32'(r));
      check("rot_slip_cnt", 32'(lnk.slip_cnt), 32'(r));
    end

    // bufg_rst for two cycles during the first WAIT.
    do_reset(rotr_n(PAT, 3));
    run_to(SETTLE + 4);
    check("bufg_in_wait", 32'(lnk.lock_state), 32'd3);
    r = pulses;
    bufg_rst = 1'b1;
    tick();
    tick();
    bufg_rst = 1'b0;
    run_to(SETTLE + 8);
    check("bufg_state", 32'(lnk.lock_state), 32'd0);
    check("bufg_slip", 32'(lnk.slip_cnt), 32'd0);
    check("bufg_retry", 32'(lnk.retry_cnt), 32'd0);
    check("bufg_no_slip", 32'(pulses), 32'(r));
    tick();
    check("bufg_held", 32'(lnk.lock_state), 32'd0);
    // Restart after edge 265 with one slip already applied: two more slips.
    run_to(265 + SETTLE + 2 * SLIP_COST + 7);
    check("recheck_state", 32'(lnk.lock_state), 32'd1);
    check("recheck_slip", 32'(lnk.slip_cnt), 32'd2);

    // Asynchronous reset in CHECK clears outputs without a clock edge.
    #2 sys_rst_n = 1'b0;
    #1 check_zero_outputs("async");

    // A word from outside the training pattern's rotation class never locks.
    do begin
      bad = 8'($urandom);
    end while (in_pat_class(bad));
    do_reset(bad);
    while (edge_n < EXH_END) begin
      tick();
      n = (edge_n < EXH_FIRST) ? 0 : 1 + (edge_n - EXH_FIRST) / EXH_PERIOD;
      exp_retry = (n > RETRY_CAP) ? RETRY_CAP : n;
      check("retry_cnt", 32'(lnk.retry_cnt), 32'(exp_retry));
      if (edge_n >= EXH_FIRST && (edge_n - EXH_FIRST) % EXH_PERIOD == 0) begin
        check("burst_pulses", 32'(pulses), 32'd8);
        pulses = 0;
        check("exh_locked", 32'(lnk.gclk_sd_lockeda), 32'd0);
        check("exh_fail", 32'(lnk.align_fail), 32'(n >= FAIL_AFTER));
        check("exh_state", 32'(lnk.lock_state), (n >= FAIL_AFTER) ? 32'd5 : 32'd0);
      end
    end
`ifdef ADC_LOCK_TIMEOUT_EN
    // FAIL is sticky even once the correct word shows up.
    word = PAT;
    pulses = 0;
    repeat (300) tick();
    check("fail_sticky", 32'(lnk.lock_state), 32'd5);
    check("fail_flag", 32'(lnk.align_fail), 32'd1);
    check("fail_nolock", 32'(lnk.gclk_sd_lockeda), 32'd0);
    check("fail_noslip", 32'(pulses), 32'd0);
    lnk.relock = 1'b1;
    tick();
    lnk.relock = 1'b0;
    base = edge_n;
    check("fail_relock_state", 32'(lnk.lock_state), 32'd0);
    check("fail_relock_flag", 32'(lnk.align_fail), 32'd0);
    check("fail_relock_retry", 32'(lnk.retry_cnt), 32'd0);
    run_to(base + SETTLE + MATCHES);
    check("fail_relock_lock", 32'(lnk.gclk_sd_lockeda), 32'd1);
`else
    check("nofail_retry_sat", 32'(lnk.retry_cnt), 32'd15);
    check("nofail_flag", 32'(lnk.align_fail), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/adc_link_lock_seq.md
Name: adc_link_lock_seq

Overview:
- Sits directly downstream of the ADC clock-input stage and runs on its divided ADC clock, clk_div_a.
- Replaces the ad-hoc "locked" counter with a sequencer. It waits for the clock to settle, then bit-aligns the deserialised ADC training word by issuing bitslip pulses.
- Asserts gclk_sd_lockeda once alignment holds, and is the source of data-valid qualification for the capture logic.

Parameters:
- DATA_W, 8, width of one deserialised ADC word; maximum slips per attempt.
- SLIP_W, 4, width of slip_cnt; must hold DATA_W.
- SETTLE_CYCLES, 256, clock cycles spent in SETTLE after any (re)start.
- MATCH_CNT, 16, consecutive matching words required to declare lock.
- SLIP_WAIT, 4, cycles waited after a bitslip before checking again.
- TRAIN_PAT, 8'hF0, expected training word; must be unique under rotation.
- MAX_RETRY, 3, retries before FAIL; used only with ADC_LOCK_TIMEOUT_EN.

Ports:
- clk_div_a  in  1  divided ADC clock; the only clock.
- sys_rst_n  in  1  asynchronous, active-low reset.
- bufg_rst  in  1  asynchronous restart request, active high; synchronised internally.
- relock  in  1  synchronous single-cycle restart request.
- adc_data  in  DATA_W  deserialised ADC word.
- bitslip  out  1  one-cycle pulse to the deserialiser.
- gclk_sd_lockeda  out  1  link locked.
- align_fail  out  1  sticky failure flag.
- slip_cnt  out  SLIP_W  slips issued in the current attempt.
- retry_cnt  out  4  restarts since last reset or relock (saturating).
- lock_state  out  3  current FSM state code.

Behaviour:
- Reset: sys_rst_n low → all outputs 0 and all counters 0. State = SETTLE (code 0).
- bufg_rst synchronisation: three-flop synchroniser, internal signal rst_sync.
  - While rst_sync=1: FSM held in SETTLE; settle, match, slip and retry counters cleared; gclk_sd_lockeda=0; align_fail cleared.
- relock=1: same effect as rst_sync, for one cycle.
  - rst_sync and relock together → same as either alone.
- adc_data is registered once (adc_data_r); every comparison uses adc_data_r.
- State codes: SETTLE=0, CHECK=1, SLIP=2, WAIT=3, LOCKED=4, FAIL=5.
- SETTLE:
  - Counter increments every cycle.
  - At count SETTLE_CYCLES-1 → CHECK, counter cleared.
- CHECK:
  - adc_data_r==TRAIN_PAT: match counter increments. On the MATCH_CNT-th consecutive match → LOCKED, and gclk_sd_lockeda is set on that same edge.
  - Mismatch, slip_cnt<DATA_W: match counter cleared → SLIP.
  - Mismatch, slip_cnt==DATA_W: rotation exhausted; retry_cnt increments (saturating at 15), slip_cnt cleared → SETTLE.
- SLIP: bitslip=1 for exactly this one cycle; slip_cnt increments → WAIT.
- WAIT: SLIP_WAIT cycles, bitslip=0 → CHECK.
- LOCKED:
  - gclk_sd_lockeda=1; data is no longer checked.
  - Leaves only on rst_sync, relock or sys_rst_n.
- FAIL (exists only with the macro):
  - Sticky; align_fail=1, gclk_sd_lockeda=0.
  - Leaves only on rst_sync, relock or sys_rst_n.
- bitslip is never asserted outside SLIP; never in consecutive cycles.
- Lock latency, pattern already aligned at release: gclk_sd_lockeda rises on edge SETTLE_CYCLES+MATCH_CNT+1 after sys_rst_n deasserts; the +1 is the input register.
- Each slip costs 1 (CHECK) + 1 (SLIP) + SLIP_WAIT cycles.

Optional Feature:
- Macro ADC_LOCK_TIMEOUT_EN.
- Defined: an exhausted rotation with retry_cnt==MAX_RETRY → FAIL instead of SETTLE; align_fail=1.
- Undefined: retries continue indefinitely; FAIL is unreachable; align_fail tied 0.

Test Plan:
1. adc_data constant 8'hF0 from reset release → gclk_sd_lockeda=1 at edge 273, zero bitslip pulses, slip_cnt=0.
2. Deserialiser model rotates the word left by one per bitslip (visible the next cycle); start word = 8'hF0 rotated right by 3 → exactly 3 bitslip pulses, slip_cnt=3, lock at edge 273+3×6=291.
3. adc_data=8'h00 constantly, macro undefined → bitslip pulses in bursts of 8; retry_cnt counts 1,2,3… saturating at 15; lock never asserted; align_fail=0.
4. Same stimulus as 3, macro defined, MAX_RETRY=3 → lock_state=5 and align_fail=1 after the 4th exhausted rotation; further data 8'hF0 has no effect until relock.
5. Locked, then a 1-cycle relock pulse → gclk_sd_lockeda=0 next edge, lock_state=0, full re-lock after 272 cycles.
6. bufg_rst asserted for 2 cycles mid-WAIT → no bitslip after sync delay; FSM in SETTLE with counters 0. sys_rst_n low mid-CHECK → all outputs 0 immediately, asynchronously.
